// File: rtl/nes_pal_pkg.sv
// Shared palette definitions for the NES video path.
// Contents:
//   PAL_ENTRIES / PAL_BYTES - palette file geometry (64 entries x 3 bytes)
//   pal_ld_state_t          - palette loader FSM states
//   rgb24_t                 - packed colour word, R[23:16], G[15:8], B[7:0]
//   rgb_set()               - replace one component of a colour word
package nes_pal_pkg;

  localparam int PAL_ENTRIES = 64;
  localparam int PAL_BYTES   = 3 * PAL_ENTRIES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } pal_ld_state_t;

  typedef logic [23:0] rgb24_t;

  // Slot 0 is R, 1 is G, 2 is B (file byte order).
  function automatic rgb24_t rgb_set(input rgb24_t word, input logic [1:0] slot,
                                     input logic [7:0] value);
    rgb24_t res;
    res = word;
    case (slot)
      2'd0:    res[23:16] = value;
      2'd1:    res[15:8]  = value;
      default: res[7:0]   = value;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pal_loader.sv
// pal_loader - turns a downloaded palette file (R,G,B byte triplets on the
// ioctl byte stream) into single-cycle palette RAM write strobes.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   pal_download          - high while a palette transfer is active
//   ioctl_wr/addr/dout    - byte strobe, byte offset in file, byte value
//   ioctl_wait            - source must not strobe while high (WRITE cycle)
//   load_color            - one-cycle palette RAM write strobe
//   load_color_index/data - entry index and {R,G,B}, valid with load_color
//   pal_loaded            - all entries written without error
//   pal_err               - protocol error seen in current/last download
module pal_loader #(
  parameter int ADDR_W      = 25,
  parameter int PAL_ENTRIES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pal_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              load_color,
  output logic [5:0]        load_color_index,
  output logic [23:0]       load_color_data,
  output logic              pal_loaded,
  output logic              pal_err
);
  import nes_pal_pkg::*;

  localparam int PAL_BYTES = 3 * PAL_ENTRIES;
  // One extra bit so a complete palette (count == PAL_ENTRIES) is representable.
  localparam int ECNT_W    = $clog2(PAL_ENTRIES + 1);

  pal_ld_state_t     state_reg, state_next;
  logic              dl_prev_reg;
  logic [7:0]        bcnt_reg;
  logic [1:0]        comp_reg;
  logic [ECNT_W-1:0] ecnt_reg;
  rgb24_t            rgb_reg;
  logic              load_reg;
  logic              wait_reg;
  logic [5:0]        index_reg;
  rgb24_t            data_reg;
  logic              loaded_reg;
  logic              err_reg;

  logic dl_rise;
  logic in_range, addr_ok, take_byte, bad_byte, entry_done, write_next;

  assign dl_rise = pal_download & ~dl_prev_reg;

  // Byte classification. A strobe during the WRITE cycle (ioctl_wait high)
  // is a protocol violation; once an error is latched the rest of the
  // download is ignored.
  always_comb begin
    in_range   = ioctl_addr < ADDR_W'(PAL_BYTES);
    addr_ok    = ioctl_addr == ADDR_W'(bcnt_reg);
    take_byte  = (state_reg == COLLECT) && ioctl_wr && !err_reg && in_range && addr_ok;
    bad_byte   = ioctl_wr && (wait_reg ||
                 ((state_reg == COLLECT) && !err_reg && in_range && !addr_ok));
    entry_done = take_byte && (comp_reg == 2'd2);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic. The download end is seen as a low level in COLLECT or
  // WRITE: both states are only reachable while pal_download was high, so a
  // low level there is the falling edge. A byte strobed together with the
  // falling edge is still accepted and its entry written before FINISH.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dl_rise) state_next = COLLECT;
      COLLECT: begin
        if (entry_done)        state_next = WRITE;
        else if (!pal_download) state_next = FINISH;
      end
      WRITE:   state_next = pal_download ? COLLECT : FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: strobe and stall are registered copies of "entering WRITE".
  always_comb begin
    write_next = (state_next == WRITE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Treat the input as already high so a level held across reset release
      // is not taken as a new download start.
      dl_prev_reg <= 1'b1;
      bcnt_reg    <= '0;
      comp_reg    <= '0;
      ecnt_reg    <= '0;
      rgb_reg     <= '0;
      load_reg    <= 1'b0;
      wait_reg    <= 1'b0;
      index_reg   <= '0;
      data_reg    <= '0;
      loaded_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      dl_prev_reg <= pal_download;
      load_reg    <= write_next;
      wait_reg    <= write_next;

      if ((state_reg == IDLE) && dl_rise) begin
        bcnt_reg   <= '0;
        comp_reg   <= '0;
        ecnt_reg   <= '0;
        err_reg    <= 1'b0;
        loaded_reg <= 1'b0;
      end

      if (bad_byte) err_reg <= 1'b1;

      if (take_byte) begin
        bcnt_reg <= bcnt_reg + 8'd1;
        rgb_reg  <= rgb_set(rgb_reg, comp_reg, ioctl_dout);
        comp_reg <= entry_done ? 2'd0 : comp_reg + 2'd1;
      end

      // Entry counter stands in for (bcnt-1)/3; it advances after each write.
      if (entry_done) begin
        data_reg  <= rgb_set(rgb_reg, comp_reg, ioctl_dout);
        index_reg <= 6'(ecnt_reg);
      end

      if (state_reg == WRITE) ecnt_reg <= ecnt_reg + ECNT_W'(1);

      if (state_reg == FINISH)
        loaded_reg <= (ecnt_reg == ECNT_W'(PAL_ENTRIES)) && !err_reg;
    end
  end

  assign load_color       = load_reg;
  assign ioctl_wait       = wait_reg;
  assign load_color_index = index_reg;
  assign load_color_data  = data_reg;
  assign pal_loaded       = loaded_reg;
  assign pal_err          = err_reg;

endmodule
